seed_arbiter: RTL and testbench

Shares one SEED128 enc/dec core among NUM_REQ requesters with round-robin arbitration.

---
 rtl/seed_pkg.sv | 25 ++
 rtl/seed_rr_pick.sv | 32 +++
 rtl/seed_arbiter.sv | 158 +++++++++++++++
 tb/tb_seed_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared definitions for the SEED core arbiter: block width, core latencies,
// FSM state encoding and the registered job record.
package seed_pkg;

    localparam int SEED_BLK_W   = 128;
    localparam int SEED_ENC_LAT = 19;
    localparam int SEED_DEC_LAT = 35;

    localparam logic [2:0] ST_ARB      = 3'd0;
    localparam logic [2:0] ST_SEND_TXT = 3'd1;
    localparam logic [2:0] ST_SEND_KEY = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    typedef struct packed {
        logic [SEED_BLK_W-1:0] text;
        logic [SEED_BLK_W-1:0] key;
        logic                  dec;
    } seed_job_t;

    function automatic int seed_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/seed_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping modulo NUM_REQ; returns a one-hot grant and its index.
module seed_rr_pick
    import seed_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [IDX_W-1:0]   i_Ptr,
    output logic [NUM_REQ-1:0] o_Gnt,
    output logic [IDX_W-1:0]   o_Idx,
    output logic               o_fAny
);

    always_comb begin
        logic [IDX_W-1:0] w_Cand;
        o_Gnt  = '0;
        o_Idx  = '0;
        o_fAny = 1'b0;
        w_Cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_Cand = IDX_W'((int'(i_Ptr) + k) % NUM_REQ);
            if (!o_fAny && i_Req[w_Cand]) begin
                o_fAny        = 1'b1;
                o_Gnt[w_Cand] = 1'b1;
                o_Idx         = w_Cand;
            end
        end
    end

endmodule

// File: rtl/seed_arbiter.sv
// Round-robin sharing of one SEED128 core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SEED_ARB_TIMEOUT_EN.
module seed_arbiter
    import seed_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic [NUM_REQ-1:0]            i_fReq,
    input  logic [NUM_REQ-1:0]            i_fDec,
    input  logic [NUM_REQ*SEED_BLK_W-1:0] i_Text,
    input  logic [NUM_REQ*SEED_BLK_W-1:0] i_Key,
    output logic [NUM_REQ-1:0]            o_fAck,
    output logic [NUM_REQ-1:0]            o_fValid,
    input  logic [NUM_REQ-1:0]            i_fRdy,
    output logic [SEED_BLK_W-1:0]         o_Text,
    output logic                          o_fErr,
    output logic                          o_fBusy,
    output logic [SEED_BLK_W-1:0]         o_Core_Text,
    output logic                          o_Core_fStart,
    output logic                          o_Core_fDec,
    input  logic [SEED_BLK_W-1:0]         i_Core_Text,
    input  logic                          i_Core_fDone
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [2:0]            r_State;
    logic [IDX_W-1:0]      r_Ptr;
    logic [IDX_W-1:0]      r_Owner;
    seed_job_t             r_Job;
    logic [SEED_BLK_W-1:0] r_Result;

    logic [NUM_REQ-1:0]    w_Gnt;
    logic [IDX_W-1:0]      w_GntIdx;
    logic                  w_fAny;
    seed_job_t             w_SelJob;
    logic [IDX_W-1:0]      w_PtrNext;
    logic                  w_fTimeout;

    seed_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_Req  (i_fReq),
        .i_Ptr  (r_Ptr),
        .o_Gnt  (w_Gnt),
        .o_Idx  (w_GntIdx),
        .o_fAny (w_fAny)
    );

    // One-hot grant drives an AND-OR select of the winning requester's job.
    always_comb begin
        w_SelJob = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_Gnt[n]) begin
                w_SelJob.text = i_Text[n*SEED_BLK_W +: SEED_BLK_W];
                w_SelJob.key  = i_Key[n*SEED_BLK_W +: SEED_BLK_W];
                w_SelJob.dec  = i_fDec[n];
            end
        end
    end

    assign w_PtrNext = (r_Owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_Owner + 1'b1;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State  <= ST_ARB;
            r_Ptr    <= '0;
            r_Owner  <= '0;
            r_Job    <= '0;
            r_Result <= '0;
        end else begin
            case (r_State)
                ST_ARB: begin
                    if (w_fAny) begin
                        r_Owner <= w_GntIdx;
                        r_Job   <= w_SelJob;
                        r_State <= ST_SEND_TXT;
                    end
                end
                ST_SEND_TXT: r_State <= ST_SEND_KEY;
                ST_SEND_KEY: r_State <= ST_WAIT;
                ST_WAIT: begin
                    if (i_Core_fDone) begin
                        r_Result <= i_Core_Text;
                        r_State  <= ST_RESP;
                    end else if (w_fTimeout) begin
                        r_Result <= '0;
                        r_State  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_fRdy[r_Owner]) begin
                        r_Ptr   <= w_PtrNext;
                        r_State <= ST_ARB;
                    end
                end
                default: r_State <= ST_ARB;
            endcase
        end
    end

`ifdef SEED_ARB_TIMEOUT_EN
    localparam int CNT_W = seed_cnt_w(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_Cnt;
    logic             r_fErr;

    assign w_fTimeout = (r_State == ST_WAIT) && (r_Cnt == CNT_W'(TIMEOUT_CYC));

    // Counter is zero on the first WAIT cycle, so it equals TIMEOUT_CYC after that many cycles.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Cnt  <= '0;
            r_fErr <= 1'b0;
        end else begin
            if (r_State == ST_SEND_KEY) begin
                r_Cnt  <= '0;
                r_fErr <= 1'b0;
            end else if (r_State == ST_WAIT) begin
                if (!w_fTimeout)
                    r_Cnt <= r_Cnt + 1'b1;
                if (w_fTimeout && !i_Core_fDone)
                    r_fErr <= 1'b1;
            end
        end
    end

    assign o_fErr = (r_State == ST_RESP) && r_fErr;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_fTimeout       = 1'b0;
    assign o_fErr           = 1'b0;
`endif

    // Ack is combinational so it lands in the accept cycle; reset masks it.
    assign o_fAck   = (r_State == ST_ARB && i_Rst) ? w_Gnt : '0;
    assign o_fBusy  = (r_State != ST_ARB);
    assign o_fValid = (r_State == ST_RESP) ? (NUM_REQ'(1) << r_Owner) : '0;
    assign o_Text   = (r_State == ST_RESP) ? r_Result : '0;

    assign o_Core_fStart = (r_State == ST_SEND_TXT);
    assign o_Core_fDec   = (r_State == ST_SEND_TXT || r_State == ST_SEND_KEY) ? r_Job.dec : 1'b0;

    always_comb begin
        o_Core_Text = '0;
        if (r_State == ST_SEND_TXT)
            o_Core_Text = r_Job.text;
        else if (r_State == ST_SEND_KEY)
            o_Core_Text = r_Job.key;
    end

endmodule

// File: tb/tb_seed_arbiter.sv
// Directed bench for seed_arbiter with a behavioural SEED core stand-in.
// The timeout scenario is compiled in only when SEED_ARB_TIMEOUT_EN is defined.
module tb_seed_arbiter;
    import seed_pkg::*;

    localparam logic [127:0] PT = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] CT = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
    localparam logic [127:0] T0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] K0 = 128'hFFFFFFFF00000000_0000000000000000;
    localparam logic [127:0] T1 = 128'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A;
    localparam logic [127:0] K1 = 128'h0;
    // Stand-in core result: halves swapped, XOR key, inverted for decrypt.
    localparam logic [127:0] R0  = 128'h0123456776543210_0123456789ABCDEF;
    localparam logic [127:0] R1  = 128'h5A5A5A5A5A5A5A5A_A5A5A5A5A5A5A5A5;
    localparam logic [127:0] R10 = 128'hA5A5A5A55A5A5A5A_A5A5A5A5A5A5A5A5;

    logic         clk;
    logic         rst;
    logic [1:0]   req, dec, rdy;
    logic [255:0] text, key;
    logic [1:0]   ack, valid;
    logic [127:0] otext, ctext, core_text;
    logic         err, busy, cstart, cdec, core_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    seed_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(63)) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_fReq        (req),
        .i_fDec        (dec),
        .i_Text        (text),
        .i_Key         (key),
        .o_fAck        (ack),
        .o_fValid      (valid),
        .i_fRdy        (rdy),
        .o_Text        (otext),
        .o_fErr        (err),
        .o_fBusy       (busy),
        .o_Core_Text   (ctext),
        .o_Core_fStart (cstart),
        .o_Core_fDec   (cdec),
        .i_Core_Text   (core_text),
        .i_Core_fDone  (core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: start+text, key next cycle, done pulse at the core latency.
    logic         stub_mute, stray_done, s_done, s_dec;
    logic [127:0] s_txt, s_key, s_out;
    int           s_phase, s_cnt;

    function automatic logic [127:0] stub_f(input logic [127:0] t, input logic [127:0] k, input logic d);
        if (k == 128'h0 && t == PT && !d) return CT;
        if (k == 128'h0 && t == CT && d) return PT;
        return {t[63:0], t[127:64]} ^ k ^ {128{d}};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_phase <= 0; s_cnt <= 0; s_done <= 1'b0; s_dec <= 1'b0;
            s_txt <= '0; s_key <= '0; s_out <= '0;
        end else begin
            s_done <= 1'b0;
            if (cstart) begin
                s_phase <= 1; s_txt <= ctext; s_dec <= cdec;
            end else if (s_phase == 1) begin
                s_phase <= 2; s_key <= ctext;
                s_cnt <= (s_dec ? SEED_DEC_LAT : SEED_ENC_LAT) - 3;
            end else if (s_phase == 2) begin
                if (s_cnt == 1) begin
                    s_phase <= 0;
                    if (!stub_mute) begin
                        s_done <= 1'b1;
                        s_out  <= stub_f(s_txt, s_key, s_dec);
                    end
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    assign core_done = s_done | stray_done;
    assign core_text = s_out;

    task automatic test_reset();
        rst = 1'b0; req = 2'b11;
        @(negedge clk); @(negedge clk); #1;
        tests_run++; if (ack !== 2'b00) begin tests_failed++; $display("FAIL rst_ack: got %b want 00", ack); end
        tests_run++; if (valid !== 2'b00) begin tests_failed++; $display("FAIL rst_valid: got %b want 00", valid); end
        tests_run++; if (otext !== 128'h0) begin tests_failed++; $display("FAIL rst_text: got %h want 0", otext); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", err); end
        tests_run++; if ({ctext, cstart, cdec} !== 130'h0) begin tests_failed++; $display("FAIL rst_core: got %h/%b/%b want 0", ctext, cstart, cdec); end
        req = 2'b00; rst = 1'b1;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_encrypt();
        int a = -1;
        text[127:0] = PT; key[127:0] = 128'h0; dec[0] = 1'b0; req = 2'b01;
        for (int i = 0; i < 10; i++) begin #1; if (ack != 2'b00) begin a = cyc; break; end @(negedge clk); end
        tests_run++; if (ack !== 2'b01) begin tests_failed++; $display("FAIL enc_ack: got %b want 01", ack); end
        @(negedge clk);
        req = 2'b00;
        tests_run++; if ({cstart, cdec, busy, ack} !== 5'b10100) begin tests_failed++; $display("FAIL enc_send_txt_ctl: got %b want 10100", {cstart, cdec, busy, ack}); end
        tests_run++; if (ctext !== PT) begin tests_failed++; $display("FAIL enc_send_txt: got %h want %h", ctext, PT); end
        @(negedge clk);
        tests_run++; if (cstart !== 1'b0) begin tests_failed++; $display("FAIL enc_send_key_start: got %b want 0", cstart); end
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (valid != 2'b00) break; end
        tests_run++; if (cyc - a !== 20) begin tests_failed++; $display("FAIL enc_latency: got %0d want 20", cyc - a); end
        tests_run++; if (valid !== 2'b01) begin tests_failed++; $display("FAIL enc_valid: got %b want 01", valid); end
        tests_run++; if (otext !== CT) begin tests_failed++; $display("FAIL enc_result: got %h want %h", otext, CT); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL enc_err: got %b want 0", err); end
        @(negedge clk);
        tests_run++; if ({valid, busy} !== 3'b000) begin tests_failed++; $display("FAIL enc_release: got %b want 000", {valid, busy}); end
    endtask

    task automatic test_decrypt();
        int a = -1;
        text[127:0] = CT; key[127:0] = 128'h0; dec[0] = 1'b1; req = 2'b01;
        for (int i = 0; i < 10; i++) begin #1; if (ack != 2'b00) begin a = cyc; break; end @(negedge clk); end
        tests_run++; if (ack !== 2'b01) begin tests_failed++; $display("FAIL dec_ack: got %b want 01", ack); end
        @(negedge clk);
        req = 2'b00;
        tests_run++; if ({cstart, cdec} !== 2'b11) begin tests_failed++; $display("FAIL dec_start: got %b want 11", {cstart, cdec}); end
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (valid != 2'b00) break; end
        tests_run++; if (cyc - a !== 36) begin tests_failed++; $display("FAIL dec_latency: got %0d want 36", cyc - a); end
        tests_run++; if (otext !== PT) begin tests_failed++; $display("FAIL dec_result: got %h want %h", otext, PT); end
        @(negedge clk);
        dec[0] = 1'b0;
    endtask

    task automatic test_key_path();
        text[255:128] = T1; key[255:128] = K0; dec[1] = 1'b0; req = 2'b10;
        for (int i = 0; i < 10; i++) begin #1; if (ack != 2'b00) break; @(negedge clk); end
        tests_run++; if (ack !== 2'b10) begin tests_failed++; $display("FAIL kp_ack: got %b want 10", ack); end
        @(negedge clk);
        req = 2'b00;
        tests_run++; if (ctext !== T1) begin tests_failed++; $display("FAIL kp_text: got %h want %h", ctext, T1); end
        @(negedge clk);
        tests_run++; if (ctext !== K0) begin tests_failed++; $display("FAIL kp_key: got %h want %h", ctext, K0); end
        @(negedge clk);
        tests_run++; if (ctext !== 128'h0) begin tests_failed++; $display("FAIL kp_wait_text: got %h want 0", ctext); end
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (valid != 2'b00) break; end
        tests_run++; if (valid !== 2'b10) begin tests_failed++; $display("FAIL kp_valid: got %b want 10", valid); end
        tests_run++; if (otext !== R10) begin tests_failed++; $display("FAIL kp_result: got %h want %h", otext, R10); end
        @(negedge clk);
    endtask

    task automatic test_stray_done();
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        tests_run++; if ({valid, busy} !== 3'b000) begin tests_failed++; $display("FAIL stray_done: got %b want 000", {valid, busy}); end
    endtask

    task automatic test_contention();
        int ngr = 0, nres = 0;
        logic [1:0] last = 2'b00;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        text = {T1, T0}; key = {K1, K0}; dec = 2'b00; rdy = 2'b11; req = 2'b11;
        #1;
        for (int i = 0; i < 200 && nres < 4; i++) begin
            if (busy) begin
                tests_run++; if (ack !== 2'b00) begin tests_failed++; $display("FAIL cont_ack_busy: got %b want 00", ack); end
            end
            if (ack != 2'b00) begin
                tests_run++; if (ack !== ((ngr % 2 == 0) ? 2'b01 : 2'b10)) begin tests_failed++; $display("FAIL cont_grant%0d: got %b want %b", ngr, ack, (ngr % 2 == 0) ? 2'b01 : 2'b10); end
                last = ack; ngr++;
            end
            if (valid != 2'b00) begin
                tests_run++; if (valid !== last) begin tests_failed++; $display("FAIL cont_valid%0d: got %b want %b", nres, valid, last); end
                tests_run++; if (otext !== ((last == 2'b01) ? R0 : R1)) begin tests_failed++; $display("FAIL cont_result%0d: got %h want %h", nres, otext, (last == 2'b01) ? R0 : R1); end
                nres++;
                if (nres == 4) req = 2'b00;
            end
            if (nres < 4) @(negedge clk);
        end
        tests_run++; if (nres !== 4) begin tests_failed++; $display("FAIL cont_count: got %0d want 4", nres); end
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL cont_idle: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        rdy = 2'b10; req = 2'b11;
        for (int i = 0; i < 10; i++) begin #1; if (ack != 2'b00) break; @(negedge clk); end
        tests_run++; if (ack !== 2'b01) begin tests_failed++; $display("FAIL bp_ack: got %b want 01", ack); end
        @(negedge clk);
        req = 2'b10;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (valid != 2'b00) break; end
        tests_run++; if ({valid, otext} !== {2'b01, R0}) begin tests_failed++; $display("FAIL bp_first: got %b/%h want 01/%h", valid, otext, R0); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++; if ({valid, ack, otext} !== {2'b01, 2'b00, R0}) begin tests_failed++; $display("FAIL bp_hold%0d: got %b/%b/%h want 01/00/%h", i, valid, ack, otext, R0); end
        end
        rdy = 2'b11;
        @(negedge clk);
        tests_run++; if ({busy, valid, ack} !== 5'b00010) begin tests_failed++; $display("FAIL bp_rearb: got %b want 00010", {busy, valid, ack}); end
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (valid != 2'b00) break; end
        tests_run++; if ({valid, otext} !== {2'b10, R1}) begin tests_failed++; $display("FAIL bp_second: got %b/%h want 10/%h", valid, otext, R1); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int a = -1, seen = 0;
        text[127:0] = PT; key[127:0] = 128'h0; dec = 2'b00; req = 2'b01;
        for (int i = 0; i < 10; i++) begin #1; if (ack != 2'b00) begin a = cyc; break; end @(negedge clk); end
        @(negedge clk);
        req = 2'b00;
        repeat (7) @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rmw_busy_before: got %b want 1 (cycle %0d)", busy, cyc - a); end
        rst = 1'b0;
        #1;
        tests_run++; if ({valid, ack, busy, err, cstart, cdec} !== 8'h00) begin tests_failed++; $display("FAIL rmw_ctl: got %b want 0", {valid, ack, busy, err, cstart, cdec}); end
        tests_run++; if ({otext, ctext} !== 256'h0) begin tests_failed++; $display("FAIL rmw_data: got %h/%h want 0", otext, ctext); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (valid != 2'b00 || busy) seen++; end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rmw_stale: got %0d active cycles want 0", seen); end
        text[127:0] = CT; dec[0] = 1'b1; req = 2'b01;
        a = -1;
        for (int i = 0; i < 10; i++) begin #1; if (ack != 2'b00) begin a = cyc; break; end @(negedge clk); end
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (valid != 2'b00) break; end
        tests_run++; if (cyc - a !== 36) begin tests_failed++; $display("FAIL rmw_latency: got %0d want 36", cyc - a); end
        tests_run++; if ({valid, otext} !== {2'b01, PT}) begin tests_failed++; $display("FAIL rmw_result: got %b/%h want 01/%h", valid, otext, PT); end
        @(negedge clk);
        dec = 2'b00;
    endtask

`ifdef SEED_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int a = -1;
        stub_mute = 1'b1;
        text[127:0] = PT; key[127:0] = 128'h0; dec = 2'b00; req = 2'b01;
        for (int i = 0; i < 10; i++) begin #1; if (ack != 2'b00) begin a = cyc; break; end @(negedge clk); end
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 150; i++) begin @(negedge clk); if (valid != 2'b00) break; end
        tests_run++; if (cyc - a !== 67) begin tests_failed++; $display("FAIL to_latency: got %0d want 67", cyc - a); end
        tests_run++; if ({valid, err, otext} !== {2'b01, 1'b1, 128'h0}) begin tests_failed++; $display("FAIL to_result: got %b/%b/%h want 01/1/0", valid, err, otext); end
        @(negedge clk);
        stub_mute = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0; req = '0; dec = '0; rdy = 2'b11; text = '0; key = '0;
        stub_mute = 1'b0; stray_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_encrypt();
        test_decrypt();
        test_key_path();
        test_stray_done();
        test_contention();
        test_backpressure();
        test_reset_mid_wait();
`ifdef SEED_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
